// File: rtl/proto_matrix_walker.sv
// Walks the QC-LDPC prototype ROM and streams non-zero blocks as (row, col, shift).
// Optional PROTO_ROW_MASK_EN adds row_mask to skip whole prototype rows.
module proto_matrix_walker #(
   parameter int Z     = 54,
   parameter int WIDTH = 6,
   parameter int ROWS  = 4,
   parameter int COLS  = 24,
   parameter int DEPTH = 96,
   parameter int ADDRW = 7
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
`ifdef PROTO_ROW_MASK_EN
   input  logic [ROWS-1:0]  row_mask,
`endif
   output logic             busy,
   output logic             done,
   output logic [ADDRW-1:0] rom_addr,
   input  logic [WIDTH-1:0] rom_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [1:0]       out_row,
   output logic [4:0]       out_col,
   output logic [WIDTH-1:0] out_shift,
   output logic [ADDRW-1:0] nnz_count
);

   if (!(Z == 27 || Z == 54 || Z == 81)) begin : g_bad_z
      $fatal(1, "proto_matrix_walker: Z must be 27, 54 or 81");
   end
   if (DEPTH != ROWS * COLS) begin : g_bad_depth
      $fatal(1, "proto_matrix_walker: DEPTH must equal ROWS*COLS");
   end

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SCAN  = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [WIDTH-1:0] SENT  = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] Z_LIM = WIDTH'(Z);

   logic [1:0] state;
   logic [1:0] row_ctr;
   logic [4:0] col_ctr;
   logic       row_en;
   logic       sentinel;
   logic       slot_free;
   logic       accept;
   logic       last_row;
   logic       last_col;

   assign sentinel  = (rom_data == SENT);
   assign accept    = out_valid && out_ready;
   assign slot_free = !out_valid || out_ready;
   assign last_row  = (row_ctr == 2'(ROWS - 1));
   assign last_col  = (col_ctr == 5'(COLS - 1));
   assign busy      = (state != S_IDLE);
   assign done      = (state == S_DONE);

`ifdef PROTO_ROW_MASK_EN
   logic [ROWS-1:0] mask_q;

   assign row_en = mask_q[row_ctr];

   // Capture the row mask for the whole pass at accepted start
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         mask_q <= '1;
      else if (state == S_IDLE && start)
         mask_q <= row_mask;
   end
`else
   assign row_en = 1'b1;
`endif

   // Scan FSM, address counters and the single-entry output slot
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         rom_addr  <= '0;
         row_ctr   <= '0;
         col_ctr   <= '0;
         out_valid <= 1'b0;
         out_row   <= '0;
         out_col   <= '0;
         out_shift <= '0;
         nnz_count <= '0;
      end else begin
         if (accept) begin
            out_valid <= 1'b0;
            nnz_count <= nnz_count + ADDRW'(1);
         end
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  state     <= S_SCAN;
                  rom_addr  <= '0;
                  row_ctr   <= '0;
                  col_ctr   <= '0;
                  nnz_count <= '0;
               end
            end
            S_SCAN: begin
               if (!row_en) begin
                  if (last_row) begin
                     state <= S_DRAIN;
                  end else begin
                     rom_addr <= rom_addr + ADDRW'(COLS);
                     row_ctr  <= row_ctr + 2'd1;
                  end
               end else if (sentinel || slot_free) begin
                  if (!sentinel) begin
                     out_valid <= 1'b1;
                     out_row   <= row_ctr;
                     out_col   <= col_ctr;
                     out_shift <= rom_data;
                  end
                  if (last_row && last_col) begin
                     state <= S_DRAIN;
                  end else begin
                     rom_addr <= rom_addr + ADDRW'(1);
                     if (last_col) begin
                        col_ctr <= '0;
                        row_ctr <= row_ctr + 2'd1;
                     end else begin
                        col_ctr <= col_ctr + 5'd1;
                     end
                  end
               end
            end
            S_DRAIN: begin
               if (!out_valid || accept)
                  state <= S_DONE;
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   a_shift_range: assert property (
      @(posedge clk) disable iff (!rst_n)
      (state == S_SCAN && row_en && !sentinel) |-> (rom_data < Z_LIM)
   );

endmodule

// File: tb/tb_proto_matrix_walker.sv
// Directed bench for proto_matrix_walker with a queue-based beat model.
// Build with +define+PROTO_ROW_MASK_EN to exercise the row-mask pass.
module tb_proto_matrix_walker;

   localparam int Z     = 54;
   localparam int WIDTH = 6;
   localparam int ROWS  = 4;
   localparam int COLS  = 24;
   localparam int DEPTH = 96;
   localparam int ADDRW = 7;
   localparam logic [WIDTH-1:0] SENT = '1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic             out_ready = 1'b1;
   logic             busy;
   logic             done;
   logic             out_valid;
   logic [ADDRW-1:0] rom_addr;
   logic [ADDRW-1:0] nnz_count;
   logic [WIDTH-1:0] rom_data;
   logic [WIDTH-1:0] out_shift;
   logic [1:0]       out_row;
   logic [4:0]       out_col;
`ifdef PROTO_ROW_MASK_EN
   logic [ROWS-1:0]  row_mask = '1;
`endif

   logic [ROWS-1:0]  mask_m = '1;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [12:0]      exp_q [$];

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int rmode = 0;
   logic exp_busy = 1'b0;
   bit done_seen = 0;
   int done_cyc = 0;
   int vcnt = 0;
   int vfirst = -1;
   int vlast = -1;

   proto_matrix_walker #(
      .Z(Z), .WIDTH(WIDTH), .ROWS(ROWS),
      .COLS(COLS), .DEPTH(DEPTH), .ADDRW(ADDRW)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
`ifdef PROTO_ROW_MASK_EN
      .row_mask(row_mask),
`endif
      .busy(busy),
      .done(done),
      .rom_addr(rom_addr),
      .rom_data(rom_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_row(out_row),
      .out_col(out_col),
      .out_shift(out_shift),
      .nnz_count(nnz_count)
   );

   assign rom_data = (int'(rom_addr) < DEPTH) ? mem[rom_addr] : SENT;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      out_ready = (rmode == 0) ? 1'b1 : ~out_ready;
   end

   task automatic check(input bit ok, input string name,
                        input int act, input int req);
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   task automatic fill_sent();
      for (int k = 0; k < DEPTH; k++) mem[k] = SENT;
   endtask

   task automatic fill_full();
      for (int k = 0; k < DEPTH; k++) mem[k] = WIDTH'(k % Z);
   endtask

   task automatic build_model();
      exp_q.delete();
      for (int r = 0; r < ROWS; r++)
         if (mask_m[r])
            for (int c = 0; c < COLS; c++)
               if (mem[r * COLS + c] != SENT)
                  exp_q.push_back({2'(r), 5'(c), mem[r * COLS + c]});
   endtask

   logic        pstall = 1'b0;
   logic [12:0] pbeat = '0;
   logic [12:0] cur;
   logic [12:0] eb;

   // Per-cycle compare against the beat queue and busy/done expectations
   always @(negedge clk) begin
      if (rst_n) begin
         cur = {out_row, out_col, out_shift};
         check(busy === exp_busy, "busy", int'(busy), int'(exp_busy));
         if (out_valid) begin
            vcnt++;
            if (vfirst < 0) vfirst = cyc;
            vlast = cyc;
            check(int'(out_shift) < Z, "shift_range", int'(out_shift), Z);
            if (pstall)
               check(cur === pbeat, "stable", int'(cur), int'(pbeat));
            if (out_ready) begin
               if (exp_q.size() == 0) begin
                  check(1'b0, "extra_beat", int'(cur), -1);
               end else begin
                  eb = exp_q.pop_front();
                  check(cur === eb, "beat", int'(cur), int'(eb));
               end
            end
         end else if (pstall) begin
            check(1'b0, "valid_retracted", 0, 1);
         end
         pstall = out_valid && !out_ready;
         pbeat = cur;
         if (done) begin
            check(exp_busy && !done_seen, "done_expected", 1, 0);
            done_seen = 1;
            done_cyc = cyc;
            exp_busy = 1'b0;
         end
      end else begin
         pstall = 1'b0;
      end
   end

   task automatic launch(output int n0);
      done_seen = 0;
      vcnt = 0;
      vfirst = -1;
      vlast = -1;
      @(posedge clk); #1;
      start = 1'b1;
      n0 = cyc;
`ifdef PROTO_ROW_MASK_EN
      row_mask = mask_m;
`endif
      @(posedge clk); #1;
      start = 1'b0;
      exp_busy = 1'b1;
   endtask

   task automatic run_pass(input string name, input int rm,
                           input int exp_done, input int exp_nnz,
                           input int exp_vcnt, input int exp_span,
                           input int ign_at);
      int n0;
      rmode = rm;
      check(exp_q.size() == exp_nnz, {name, "_model"},
            exp_q.size(), exp_nnz);
      launch(n0);
      for (int i = 0; i < 600 && !done_seen; i++) begin
         @(posedge clk); #1;
         start = (ign_at > 0 && cyc == n0 + ign_at);
      end
      start = 1'b0;
      check(done_seen, {name, "_done_timeout"}, int'(done_seen), 1);
      if (exp_done > 0)
         check(done_cyc - n0 == exp_done, {name, "_done_cycle"},
               done_cyc - n0, exp_done);
      check(exp_q.size() == 0, {name, "_missing"}, exp_q.size(), 0);
      check(int'(nnz_count) == exp_nnz, {name, "_nnz"},
            int'(nnz_count), exp_nnz);
      if (exp_vcnt >= 0)
         check(vcnt == exp_vcnt, {name, "_valid_cycles"}, vcnt, exp_vcnt);
      if (exp_span >= 0) begin
         check(vfirst - n0 == 2, {name, "_first_valid"}, vfirst - n0, 2);
         check(vlast - vfirst == exp_span, {name, "_span"},
               vlast - vfirst, exp_span);
      end
      repeat (3) @(posedge clk);
      #1;
      rmode = 0;
   endtask

   initial begin
      int n0;
      fill_sent();
      #12;
      check(out_valid === 1'b0, "rst_valid", int'(out_valid), 0);
      check(busy === 1'b0, "rst_busy", int'(busy), 0);
      check(done === 1'b0, "rst_done", int'(done), 0);
      check(rom_addr === '0, "rst_addr", int'(rom_addr), 0);
      check({out_row, out_col, out_shift} === '0, "rst_fields",
            int'({out_row, out_col, out_shift}), 0);
      check(nnz_count === '0, "rst_nnz", int'(nnz_count), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // single non-zero entry
      fill_sent();
      mem[0] = 6'd5;
      build_model();
      check(exp_q[0] == {2'd0, 5'd0, 6'd5}, "pin_t1", int'(exp_q[0]), 5);
      run_pass("t1", 0, 98, 1, 1, 0, 0);

      // dense matrix, full rate
      fill_full();
      build_model();
      check(exp_q[60] == {2'd2, 5'd12, 6'd6}, "pin_t2",
            int'(exp_q[60]), int'({2'd2, 5'd12, 6'd6}));
      run_pass("t2", 0, 98, 96, 96, 95, 0);

      // dense matrix, ready toggling
      build_model();
      run_pass("t3", 1, -1, 96, -1, -1, 0);

      // all sentinel, start during busy ignored
      fill_sent();
      build_model();
      run_pass("t4", 0, 98, 0, 0, -1, 30);

      // reset mid-pass with beat pending
      fill_full();
      build_model();
      rmode = 0;
      launch(n0);
      while (cyc < n0 + 40) begin
         @(posedge clk); #1;
      end
      check(out_valid === 1'b1, "t5_pending", int'(out_valid), 1);
      rst_n = 1'b0;
      exp_busy = 1'b0;
      exp_q.delete();
      #1;
      check(out_valid === 1'b0, "t5_rst_valid", int'(out_valid), 0);
      check(busy === 1'b0, "t5_rst_busy", int'(busy), 0);
      check(rom_addr === '0, "t5_rst_addr", int'(rom_addr), 0);
      check(nnz_count === '0, "t5_rst_nnz", int'(nnz_count), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      check(!done_seen, "t5_no_done", int'(done_seen), 0);
      build_model();
      run_pass("t5b", 0, 98, 96, 96, 95, 0);

`ifdef PROTO_ROW_MASK_EN
      // row 2 masked off
      mask_m = 4'b1011;
      fill_full();
      build_model();
      run_pass("t6", 0, 75, 72, 72, 72, 0);
      mask_m = '1;
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
